// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory load arbiter.
package imem_pkg;

  localparam int unsigned IMEM_INSTR_WIDTH = 32;
  localparam int unsigned IMEM_DEPTH       = 9;
  localparam int unsigned BYTES_PER_WORD   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles loader bytes big-endian into words; first byte lands in the top lane.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          byte_en,
  input  logic [7:0]                    byte_data,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_valid
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [CntW-1:0]               cnt_q;
  logic [8*BYTES_PER_WORD-1:0]   shift_q;

  // Counter wraps naturally from the last lane back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_en) begin
      cnt_q   <= cnt_q + 1'b1;
      shift_q <= {shift_q[8*BYTES_PER_WORD-9:0], byte_data};
    end
  end

  assign word       = shift_q;
  assign word_valid = byte_en && (cnt_q == CntW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction memory between a byte-serial loader and the core fetch port.
// Optional checksum phase enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = IMEM_INSTR_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = IMEM_DEPTH,
  parameter int unsigned IDX_W       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [IDX_W:0]         load_len,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  logic [ADDR_WIDTH-1:0]  cpu_fetch_addr,
  output logic [INSTR_WIDTH-1:0] cpu_instr,
  output logic                   cpu_stall,
  output logic                   mem_we,
  output logic [IDX_W-1:0]       mem_waddr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic [IDX_W-1:0]       mem_raddr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   load_done,
  output logic                   load_error
);

  localparam logic [IDX_W:0] DepthL = (IDX_W + 1)'(DEPTH);

  state_e                 state_q, state_d;
  logic [IDX_W:0]         word_cnt_q, len_q;
  logic                   load_error_q;
  logic [INSTR_WIDTH-1:0] word;
  logic                   word_valid, byte_en, start_ok, last_word, chk_phase, chk_bad;
  logic [IDX_W-1:0]       fetch_row;
  logic                   fetch_ok;

  assign byte_en   = byte_valid && byte_ready;
  assign start_ok  = (state_q == StIdle) && load_start && (load_len != '0) && (load_len <= DepthL);
  assign last_word = (word_cnt_q + 1'b1) == len_q;
  assign fetch_row = cpu_fetch_addr[IDX_W+1:2];
  assign fetch_ok  = (cpu_fetch_addr[1:0] == 2'b00) && ({1'b0, fetch_row} < DepthL);

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam state_e AfterLast = StLoad;
  logic                   chk_phase_q;
  logic [INSTR_WIDTH-1:0] xor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_phase_q <= 1'b0;
      xor_q       <= '0;
    end else if (start_ok) begin
      chk_phase_q <= 1'b0;
      xor_q       <= '0;
    end else if (state_q == StWrite) begin
      xor_q <= xor_q ^ word;
      if (last_word) chk_phase_q <= 1'b1;
    end
  end

  assign chk_phase = chk_phase_q;
  // The 4th checksum byte is still on the input, so compare the word as it would be packed.
  assign chk_bad   = chk_phase_q && word_valid && ({word[INSTR_WIDTH-9:0], byte_data} != xor_q);
`else
  localparam state_e AfterLast = StDone;
  assign chk_phase = 1'b0;
  assign chk_bad   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      len_q        <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        word_cnt_q   <= '0;
        len_q        <= load_len;
        load_error_q <= 1'b0;
      end else if ((state_q == StIdle) && load_start) begin
        load_error_q <= 1'b1;
      end
      if (state_q == StWrite) word_cnt_q <= word_cnt_q + 1'b1;
      if (chk_bad) load_error_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StLoad;
      StLoad:  if (word_valid) state_d = chk_phase ? StDone : StWrite;
      StWrite: state_d = last_word ? AfterLast : StLoad;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_stall  = 1'b0;
    mem_we     = 1'b0;
    load_done  = 1'b0;
    cpu_instr  = '0;
    unique case (state_q)
      StIdle:  cpu_instr = fetch_ok ? mem_rdata : '0;
      StLoad: begin
        cpu_stall  = 1'b1;
        byte_ready = 1'b1;
      end
      StWrite: begin
        cpu_stall = 1'b1;
        mem_we    = 1'b1;
      end
      StDone: begin
        load_done = 1'b1;
        cpu_instr = fetch_ok ? mem_rdata : '0;
      end
      default: ;
    endcase
  end

  assign mem_waddr  = word_cnt_q[IDX_W-1:0];
  assign mem_wdata  = mem_we ? word : '0;
  assign mem_raddr  = fetch_row;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a small behavioural memory beside it.
module tb_imem_load_arbiter;

  localparam int unsigned IDX_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [IDX_W:0]    load_len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic [31:0]       cpu_fetch_addr = '0;
  logic [31:0]       cpu_instr;
  logic              cpu_stall;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;
  logic [IDX_W-1:0]  mem_raddr;
  logic [31:0]       mem_rdata;
  logic              load_done;
  logic              load_error;

  imem_load_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .load_start     (load_start),
    .load_len       (load_len),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .cpu_fetch_addr (cpu_fetch_addr),
    .cpu_instr      (cpu_instr),
    .cpu_stall      (cpu_stall),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  // Memory covers every index value so out-of-range rows return visible non-zero data.
  logic [31:0] mem [0:15];
  logic        mem_init = 1'b1;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  assign mem_rdata = mem[mem_raddr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [IDX_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    #1;
    while (!byte_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    mem_init = 1'b0;
    rst      = 1'b0;
    tick();

    cpu_fetch_addr = 32'd0;
    #1;
    check("idle_raddr0", 32'(mem_raddr), 32'd0);
    check("idle_instr0", cpu_instr, 32'hA5A5_0000);

    // Illegal lengths: flag error, no load.
    start(5'd0);
    check("len0_error", 32'(load_error), 32'd1);
    check("len0_stall", 32'(cpu_stall), 32'd0);
    check("len0_ready", 32'(byte_ready), 32'd0);
    start(5'd10);
    check("len10_error", 32'(load_error), 32'd1);
    check("len10_stall", 32'(cpu_stall), 32'd0);
    check("len_bad_writes", 32'(we_cnt), 32'd0);

    // Reset in the middle of a load.
    start(5'd3);
    check("start_clr_error", 32'(load_error), 32'd0);
    check("load_stall", 32'(cpu_stall), 32'd1);
    check("load_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0);
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(cpu_stall), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    repeat (2) tick();
    rst        = 1'b0;
    byte_valid = 1'b1;
    repeat (8) tick();
    check("idle_ignores_bytes", 32'(byte_ready), 32'd0);
    check("midrst_writes", 32'(we_cnt), 32'd1);
    check("midrst_row0", mem[0], 32'h1011_1213);
    byte_valid = 1'b0;

    // Two-word load with back-to-back bytes.
    start(5'd2);
    check("l2_stall", 32'(cpu_stall), 32'd1);
    send_word(32'h2002_0007, 0);
    send_word(32'h0000_0000, 0);
    #1;
    check("l2_we", 32'(mem_we), 32'd1);
    check("l2_waddr", 32'(mem_waddr), 32'd1);
    check("l2_wdata", mem_wdata, 32'd0);
    tick();
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_word(32'h2002_0007, 0);
    #1;
`endif
    check("l2_done", 32'(load_done), 32'd1);
    check("l2_done_stall", 32'(cpu_stall), 32'd0);
    check("l2_error", 32'(load_error), 32'd0);
    check("l2_writes", 32'(we_cnt), 32'd3);
    tick();
    check("l2_done_pulse", 32'(load_done), 32'd0);
    check("l2_row0", mem[0], 32'h2002_0007);
    check("l2_row1", mem[1], 32'h0000_0000);

    // Fetch path after the load.
    cpu_fetch_addr = 32'd4;
    #1;
    check("f4_raddr", 32'(mem_raddr), 32'd1);
    check("f4_instr", cpu_instr, 32'h0000_0000);
    cpu_fetch_addr = 32'd0;
    #1;
    check("f0_instr", cpu_instr, 32'h2002_0007);
    cpu_fetch_addr = 32'd2;
    #1;
    check("f2_unaligned", cpu_instr, 32'd0);
    cpu_fetch_addr = 32'd6;
    #1;
    check("f6_unaligned", cpu_instr, 32'd0);
    cpu_fetch_addr = 32'd8;
    #1;
    check("f8_instr", cpu_instr, 32'hA5A5_0002);
    cpu_fetch_addr = 32'd36;
    #1;
    check("f36_raddr", 32'(mem_raddr), 32'd9);
    check("f36_instr", cpu_instr, 32'd0);

    // Gapped bytes, plus a load_start mid-load that must be ignored.
    start(5'd2);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    load_start = 1'b1;
    load_len   = 5'd0;
    tick();
    load_start = 1'b0;
    #1;
    check("busy_start_error", 32'(load_error), 32'd0);
    check("busy_start_stall", 32'(cpu_stall), 32'd1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    send_word(32'h5566_7788, 1);
    tick();
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_word(32'h4444_44CC, 1);
    #1;
`endif
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_error", 32'(load_error), 32'd0);
    tick();
    check("gap_row0", mem[0], 32'h1122_3344);
    check("gap_row1", mem[1], 32'h5566_7788);

`ifdef IMEM_LOAD_CHECKSUM_EN
    start(5'd1);
    send_word(32'h1234_5678, 0);
    tick();
    send_word(32'h1234_5678, 0);
    #1;
    check("csum_ok_done", 32'(load_done), 32'd1);
    check("csum_ok_error", 32'(load_error), 32'd0);
    tick();
    start(5'd1);
    send_word(32'h1234_5678, 0);
    tick();
    send_word(32'h1234_5679, 0);
    #1;
    check("csum_bad_done", 32'(load_done), 32'd1);
    check("csum_bad_error", 32'(load_error), 32'd1);
    tick();
    check("csum_bad_sticky", 32'(load_error), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
